nibble_serial_negator: RTL
==========================

# nibble_serial_negator

- Nibble-serial two's-complement unit: negates (NEG) or takes the absolute value (ABS) of a WIDTH-bit operand.
- Processes one 4-bit slice per clock through a single four_bit_rca, with the carry registered between slices.
- Sits directly upstream of, and drives, the four_bit_rca adder stage: operand conditioning, carry sequencing and result assembly are all done here.
- Valid/ready handshakes on both the input and output sides.

## Interface

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  single clock; everything is updated on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, two's complement.
- in_op  input  1  operation: 0 = NEG, 1 = ABS.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  overflow: the result is not representable.

## Operation

- NIB = WIDTH/4 slices; slice 0 is the least-significant nibble.
- inv (per transaction):
  - NEG: inv = 1.
  - ABS: inv = in_data[WIDTH-1].
- Per slice k, drive the four_bit_rca with:
  - A = nibble_k XOR {4{inv}}.
  - B = 4'b0000.
  - Cin = carry_q.
- Carry handling:
  - carry_q is loaded with inv at accept.
  - carry_q takes Cout after each slice.
  - The final Cout is discarded.
- Slice sum S is written into bits [4k+3:4k] of the result register.
- Overflow:
  - out_ovf = inv AND operand MSB AND result MSB.
  - This is set only for the most-negative operand (1 followed by zeros), in both NEG and ABS.
  - The result in that case is the most-negative value itself.
  - NEG of 0 gives 0 with out_ovf = 0.
- FSM with states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch operand and inv, set carry_q = inv and slice counter = 0, go to RUN.
  - RUN: process one slice per cycle and increment the counter. After slice NIB-1 is processed, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. Inputs presented then are ignored, not queued.
- out_data and out_ovf hold stable while out_valid = 1. They retain the last result after the handshake.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_ovf 0, carry_q 0, counter 0.
- rst_n low in any state, including mid-RUN or DONE with out_valid high:
  - The next edge returns the block to the reset values.
  - Any partial result is dropped.

## Timing

- Accept at edge T → RUN covers edges T+1 through T+NIB → out_valid high after edge T+NIB.
- Latency is NIB+1 cycles from accept to out_valid. For WIDTH = 16 this is 5.
- Earliest next accept is one cycle after the output handshake, giving a peak throughput of one operand per NIB+2 cycles.
- The combinational path is one four_bit_rca plus the XOR conditioning. No input-to-output combinational paths.
- out_ready held low: DONE persists indefinitely with outputs stable.
- in_valid high in DONE together with out_ready high: the output completes and the new operand is accepted on the next IDLE cycle.

## Structure

- Package nsn_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the op encodings OP_NEG = 0 and OP_ABS = 1;
  - the helper constant NIB_OF(WIDTH) = WIDTH/4.
- One sub-module instance: the existing four_bit_rca, ports A, B, Cin, S, Cout. No other sub-modules.
- Counter width is $clog2(NIB), minimum 1.

## Test plan (WIDTH = 16)

- NEG 0x0001, out_ready tied high → out_data 0xFFFF, out_ovf 0; out_valid rises exactly 5 cycles after accept.
- NEG 0x0000 → 0x0000, ovf 0. NEG 0x8000 → 0x8000, ovf 1. NEG 0x7FFF → 0x8001, ovf 0.
- ABS 0xFFF6 → 0x000A. ABS 0x1234 → 0x1234 with carry_q 0 throughout. ABS 0x8000 → 0x8000, ovf 1.
- Backpressure: out_ready low for 3 cycles in DONE → out_valid and out_data stable, in_ready 0, a competing in_valid ignored; out_ready high → IDLE next cycle.
- rst_n low during the 2nd RUN cycle of NEG 0x00F0 → next edge gives in_ready 1, out_valid 0, out_data 0; a subsequent NEG 0x0003 → 0xFFFD.
- Back-to-back: NEG 0x0010 then ABS 0xFF00 → 0xFFF0, then 0x0100, in order, one per NIB+2 cycles.

Source files
------------

// File: rtl/nsn_pkg.sv
// Shared types and constants for the nibble-serial negator.
package nsn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } nsn_state_e;

  localparam logic OP_NEG = 1'b0;
  localparam logic OP_ABS = 1'b1;

  // Number of 4-bit slices in a WIDTH-bit operand.
  function automatic int unsigned NIB_OF(input int unsigned width);
    return width / 4;
  endfunction

endpackage

// File: rtl/four_bit_rca.sv
// Four-bit ripple-carry adder stage.
module four_bit_rca (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  assign {Cout, S} = 5'(A) + 5'(B) + 5'(Cin);

endmodule

// File: rtl/nibble_serial_negator.sv
// Nibble-serial two's-complement NEG / ABS unit built around a single four_bit_rca.
// Each RUN cycle conditions one operand nibble, adds the registered carry, and
// writes the sum into the matching nibble of the working result.
module nibble_serial_negator
  import nsn_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned NIB  = NIB_OF(WIDTH);
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

  nsn_state_e       state_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] out_data_q;
  logic [CntW-1:0]  cnt_q;
  logic             inv_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_ovf_q;

  logic             inv_in;
  logic [3:0]       slice_a;
  logic [3:0]       slice_s;
  logic             slice_cout;

  // Per-transaction inversion flag: NEG always inverts, ABS only for negative operands.
  always_comb begin
    inv_in = 1'b1;
    unique case (in_op)
      OP_NEG:  inv_in = 1'b1;
      OP_ABS:  inv_in = in_data[WIDTH-1];
      default: inv_in = 1'b1;
    endcase
  end

  // Condition the current nibble and splice the slice sum into the working result.
  always_comb begin
    slice_a = opnd_q[{cnt_q, 2'b00} +: 4] ^ {4{inv_q}};
    res_d   = res_q;
    res_d[{cnt_q, 2'b00} +: 4] = slice_s;
  end

  four_bit_rca u_rca (
    .A    (slice_a),
    .B    (4'b0000),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opnd_q      <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            opnd_q     <= in_data;
            inv_q      <= inv_in;
            carry_q    <= inv_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          res_q <= res_d;
          if (cnt_q == LastCnt) begin
            // Final carry-out is meaningless for negation and is dropped.
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= res_d;
            out_ovf_q   <= inv_q & opnd_q[WIDTH-1] & slice_s[3];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
